// File: rtl/eq_serial_cmp_ctrl_amisha_pkg.sv
// Shared definitions for the bit-serial equality controller:
// FSM state type, default operand width and index-width helper.
package eq_serial_pkg_amisha;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;

  // Width of a bit index into a w-bit operand; never narrower than one bit.
  function automatic int unsigned idxw_f(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/eq_serial_cmp_ctrl_amisha_eq1_bit.sv
// Combinational 1-bit equality cell (XNOR of the two input bits).
module eq1_bit_amisha (
  input  logic a_bit_amisha,
  input  logic b_bit_amisha,
  output logic eq_bit_amisha
);

  assign eq_bit_amisha = ~(a_bit_amisha ^ b_bit_amisha);

endmodule

// File: rtl/eq_serial_cmp_ctrl_amisha.sv
// LSB-first bit-serial equality controller around a single shared 1-bit
// equality cell. Reports whole-word equality and the lowest mismatching
// bit index under a start/done handshake.
// Optional feature macro: EQ_SERIAL_EARLY_EXIT_EN -- leave SCAN on the
// first mismatching bit instead of always scanning all WIDTH bits.
module eq_serial_cmp_ctrl_amisha
  import eq_serial_pkg_amisha::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                            clk_amisha,
  input  logic                            rst_n_amisha,
  input  logic                            start_amisha,
  input  logic [WIDTH-1:0]                a_amisha,
  input  logic [WIDTH-1:0]                b_amisha,
  output logic                            busy_amisha,
  output logic                            done_amisha,
  output logic                            eq_amisha,
  output logic [idxw_f(WIDTH)-1:0]        mismatch_idx_amisha
);

  localparam int unsigned IDXW = idxw_f(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   cnt_q, cnt_d;
  logic              run_eq_q, run_eq_d;
  logic [IDXW-1:0]   rec_idx_q, rec_idx_d;
  logic              eq_q, eq_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;

  logic              bit_eq;
  logic              last_bit;
  logic              first_mm;
  logic              scan_exit;

  // The only comparison hardware: one cell fed with the current bit.
  eq1_bit_amisha u_eq1 (
    .a_bit_amisha  (a_q[cnt_q]),
    .b_bit_amisha  (b_q[cnt_q]),
    .eq_bit_amisha (bit_eq)
  );

  assign last_bit = (cnt_q == LAST_IDX);
  assign first_mm = run_eq_q & ~bit_eq;

`ifdef EQ_SERIAL_EARLY_EXIT_EN
  assign scan_exit = last_bit | ~bit_eq;
`else
  assign scan_exit = last_bit;
`endif

  // Next-state, datapath and result computation.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    run_eq_d  = run_eq_q;
    rec_idx_d = rec_idx_q;
    eq_d      = eq_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_amisha) begin
          state_d   = ST_SCAN;
          a_d       = a_amisha;
          b_d       = b_amisha;
          cnt_d     = '0;
          run_eq_d  = 1'b1;
          rec_idx_d = '0;
          eq_d      = 1'b0;
          idx_d     = '0;
        end
      end
      ST_SCAN: begin
        run_eq_d = run_eq_q & bit_eq;
        if (first_mm) rec_idx_d = cnt_q;
        // Counter saturates at the last bit rather than wrapping.
        if (!last_bit) cnt_d = cnt_q + 1'b1;
        // Result registers take the values that include this cycle's bit.
        if (scan_exit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          eq_d    = run_eq_d;
          idx_d   = rec_idx_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      run_eq_q  <= 1'b0;
      rec_idx_q <= '0;
      eq_q      <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      run_eq_q  <= run_eq_d;
      rec_idx_q <= rec_idx_d;
      eq_q      <= eq_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  assign busy_amisha         = (state_q != ST_IDLE);
  assign done_amisha         = done_q;
  assign eq_amisha           = eq_q;
  assign mismatch_idx_amisha = idx_q;

endmodule

// File: tb/tb_eq_serial_cmp_ctrl_amisha.sv
// Scoreboard bench for eq_serial_cmp_ctrl_amisha: a reference model turns each
// accepted start into an expected result and done edge; a negedge monitor
// checks busy, held eq/idx and every done pulse against it.
module tb_eq_serial_cmp_ctrl_amisha;

  localparam int unsigned W    = 8;
  localparam int unsigned IDXW = (W <= 1) ? 1 : $clog2(W);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    a_in = '0;
  logic [W-1:0]    b_in = '0;
  logic            busy, done, eq;
  logic [IDXW-1:0] idx;

  eq_serial_cmp_ctrl_amisha #(.WIDTH(W)) dut (
    .clk_amisha          (clk),
    .rst_n_amisha        (rst_n),
    .start_amisha        (start),
    .a_amisha            (a_in),
    .b_amisha            (b_in),
    .busy_amisha         (busy),
    .done_amisha         (done),
    .eq_amisha           (eq),
    .mismatch_idx_amisha (idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            eq;
    logic [IDXW-1:0] idx;
    int              done_e;
  } exp_t;

  exp_t sb[$];

  int n_vec  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int next_free = 0;

  // Current / previous compare as seen by the model.
  bit              cur_valid = 1'b0;
  int              cur_e0 = 0;
  int              cur_done = 0;
  logic            cur_eq = 1'b0;
  logic [IDXW-1:0] cur_idx = '0;
  logic            prev_eq = 1'b0;
  logic [IDXW-1:0] prev_idx = '0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Equality is a==b; the index is the lowest bit where they differ.
  function automatic void ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic e, output int k);
    e = (a == b);
    k = 0;
    for (int i = int'(W) - 1; i >= 0; i--)
      if (a[i] != b[i]) k = i;
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
    logic e;
    int   k;
    int   lat;
    exp_t x;
    ref_cmp(a, b, e, k);
    lat = int'(W);
`ifdef EQ_SERIAL_EARLY_EXIT_EN
    if (!e) lat = k + 1;
`endif
    prev_eq   = cur_valid ? cur_eq  : 1'b0;
    prev_idx  = cur_valid ? cur_idx : '0;
    cur_valid = 1'b1;
    cur_e0    = e0;
    cur_done  = e0 + lat;
    cur_eq    = e;
    cur_idx   = IDXW'(k);
    next_free = cur_done + 2;
    x.eq = e; x.idx = IDXW'(k); x.done_e = cur_done;
    sb.push_back(x);
  endtask

  // Drive one cycle of inputs; the model decides whether the start is taken.
  task automatic step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start = s; a_in = a; b_in = b;
    if (s && rst_n && (edge_cnt + 1) >= next_free) accept(a, b, edge_cnt + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0;
    sb.delete();
    cur_valid = 1'b0; prev_eq = 1'b0; prev_idx = '0;
    next_free = 0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: busy window, held result registers, and scoreboard on done.
  always @(negedge clk) begin
    logic            exp_busy;
    logic            exp_eq;
    logic [IDXW-1:0] exp_idx;
    exp_t            x;
    exp_busy = cur_valid && edge_cnt >= cur_e0 && edge_cnt <= cur_done;
    if (!cur_valid)              begin exp_eq = 1'b0;    exp_idx = '0;       end
    else if (edge_cnt < cur_e0)  begin exp_eq = prev_eq; exp_idx = prev_idx; end
    else if (edge_cnt < cur_done) begin exp_eq = 1'b0;   exp_idx = '0;       end
    else                         begin exp_eq = cur_eq;  exp_idx = cur_idx;  end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("eq_hold", 32'(eq), 32'(exp_eq));
    chk("idx_hold", 32'(idx), 32'(exp_idx));
    if (done) begin
      if (sb.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else begin
        x = sb.pop_front();
        chk("done_eq", 32'(eq), 32'(x.eq));
        chk("done_idx", 32'(idx), 32'(x.idx));
        chk("done_edge", 32'(edge_cnt), 32'(x.done_e));
      end
    end else if (sb.size() > 0 && edge_cnt >= sb[0].done_e) begin
      chk("done_missing", 32'(done), 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed cases.
    step(1'b1, 8'hA5, 8'hA5); idle(W + 3);
    step(1'b1, 8'hA5, 8'hA4); idle(W + 3);
    step(1'b1, 8'h80, 8'h00); idle(W + 3);
    step(1'b1, 8'hF0, 8'h0F); idle(W + 3);

    // Start pulsed mid-scan with different operands is ignored.
    step(1'b1, 8'h3C, 8'h3C); idle(2);
    step(1'b1, 8'h00, 8'hFF); idle(W + 3);

    // Start held high: back-to-back compares on fresh operands each cycle.
    for (int i = 0; i < 3 * (W + 2) + 1; i++) step(1'b1, $urandom, $urandom);
    idle(W + 3);

    // Reset in the fourth SCAN cycle, then a normal compare.
    step(1'b1, 8'h55, 8'h54); idle(3);
    do_reset(2);
    idle(1);
    step(1'b1, 8'h6E, 8'h6E); idle(W + 3);
    step(1'b1, 8'h6E, 8'h4E); idle(W + 3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
      ra = $urandom;
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = $urandom;
      endcase
      step($urandom_range(0, 2) == 0, ra, rb);
    end
    idle(2 * W + 4);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_serial_cmp_ctrl_amisha.md
# eq_serial_cmp_ctrl_amisha

Sequencing controller that shares a single 1-bit equality cell across the bits of two WIDTH-bit operands. It performs an LSB-first, bit-serial equality check under a start/done handshake. It reports whole-word equality and the index of the first mismatching bit. It sits above the gate-level 1-bit comparator and is the team's first clocked wrapper around that cell.

## Interface
- WIDTH, 8, operand width in bits; legal range 1..64.
- IDXW, max(1,$clog2(WIDTH)), derived width of the bit index; not overridden by users.

- clk_amisha  input  1  single clock; all state updates on the rising edge.
- rst_n_amisha  input  1  reset, asynchronous, active-low.
- start_amisha  input  1  request a compare; sampled only in IDLE.
- a_amisha  input  WIDTH  operand A; captured on the accepting edge.
- b_amisha  input  WIDTH  operand B; captured on the accepting edge.
- busy_amisha  output  1  high in SCAN and DONE.
- done_amisha  output  1  one-cycle pulse; result valid.
- eq_amisha  output  1  1 = operands equal; held until the next accepted start.
- mismatch_idx_amisha  output  IDXW  index of the lowest mismatching bit; 0 when eq_amisha = 1.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE to SCAN when start_amisha = 1. On that edge:
  - capture a_amisha and b_amisha into internal registers;
  - set bit counter to 0;
  - set running-equal flag to 1;
  - clear eq_amisha and mismatch_idx_amisha.
- In SCAN, each cycle drives captured bit [cnt] of A and B into the shared 1-bit eq cell.
  - If the cell output is 0 and the running flag is still 1: clear the flag and record cnt as the mismatch index. Only the first mismatch is recorded.
  - cnt increments by 1 per cycle.
- SCAN to DONE on the edge that evaluates bit WIDTH-1. The early-exit build can leave SCAN sooner; see Configuration.
- On entry to DONE: done_amisha = 1, eq_amisha = running flag, mismatch_idx_amisha = recorded index.
- DONE to IDLE unconditionally on the next edge; done_amisha returns to 0.
- start_amisha is ignored in SCAN and DONE, with no queuing.
- Operand inputs may change freely after the accepting edge.
- The counter never wraps: SCAN exits when cnt = WIDTH-1.

## Timing
- Reset values: state IDLE, busy 0, done 0, eq 0, mismatch_idx 0, counter 0. Internal operand registers are also cleared.
- Reset asserted mid-SCAN or mid-DONE: all of the above take effect immediately. The aborted compare yields no done pulse.
- Latency: start is sampled at edge E0. done is high for exactly the cycle after edge E0+WIDTH, when early exit is off.
- Throughput: one compare per WIDTH+2 cycles. A start held high continuously is accepted on the edge after DONE.
- WIDTH = 1: SCAN lasts one cycle; done is high after E1.
- busy rises after E0 and falls after the DONE-to-IDLE edge.

## Configuration
- Macro: EQ_SERIAL_EARLY_EXIT_EN.
- Defined: when the cell reports a mismatch in SCAN, the FSM goes to DONE on that same edge. Latency for a first mismatch at index k is k+1 edges after E0. Equal operands still take WIDTH edges.
- Undefined: SCAN always runs all WIDTH bits. Latency is fixed, independent of data.
- eq_amisha and mismatch_idx_amisha values are identical in both builds.

## Structure
- Shared package eq_serial_pkg_amisha holds:
  - the state enum typedef (IDLE, SCAN, DONE);
  - the default WIDTH constant;
  - the IDXW computation function.
- One sub-module: eq1_bit_amisha, a purely combinational 1-bit XNOR-based equality cell, instantiated once. The controller contains no other comparison logic.

## Test plan
- Equal operands, WIDTH=8, a=0xA5, b=0xA5 -> done pulses one cycle after E8, eq=1, idx=0, busy high for 9 cycles.
- LSB mismatch, a=0xA5, b=0xA4 -> eq=0, idx=0. Early-exit build: done after E1. Other build: done after E8.
- MSB mismatch, a=0x80, b=0x00 -> eq=0, idx=7, done after E8 in both builds.
- Multiple mismatches, a=0xF0, b=0x0F -> eq=0, idx=0 (lowest bit); idx is not overwritten later.
- start pulsed during SCAN with different operands -> ignored; result matches the first operands and there is only one done pulse. Back-to-back held start -> second compare accepted on the edge after DONE.
- rst_n_amisha low at cycle 4 of SCAN -> outputs immediately reset, no done. A new start after release completes normally with correct eq.
